// File: rtl/mem_wb_stage.sv
// MEM/WB boundary: load extraction, writeback select, WB registers, misalign flag, retire counter.
// Latency: one cycle from MEM-stage inputs to WB outputs.
// Backpressure: stall holds every WB register; flush overrides stall and inserts a bubble.
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             reg_write_in,
  input  logic [1:0]       wb_sel,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rd_in,
  input  logic [XLEN-1:0]  ALU_result,
  input  logic [XLEN-1:0]  mem_data,
  input  logic [XLEN-1:0]  pc_plus4,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             misalign_err,
  output logic [XLEN-1:0]  misalign_addr,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  logic [1:0]      off;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] sel_data;
  logic            misaligned;
  logic            advance;

  assign off = ALU_result[1:0];

  // A register update only happens on an edge that is neither flushed nor stalled.
  assign advance = !flush && !stall;

  // Pick the addressed byte/half out of the aligned memory word.
  always_comb begin
    load_byte = mem_data[7:0];
    case (off)
      2'd0: load_byte = mem_data[7:0];
      2'd1: load_byte = mem_data[15:8];
      2'd2: load_byte = mem_data[23:16];
      2'd3: load_byte = mem_data[31:24];
      default: load_byte = mem_data[7:0];
    endcase
    load_half = off[1] ? mem_data[31:16] : mem_data[15:0];
  end

  // Sign/zero extension by load type; any undefined encoding behaves as lw.
  always_comb begin
    load_data = mem_data;
    case (funct3)
      F3_LB:   load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, load_byte};
      F3_LH:   load_data = {{(XLEN-16){load_half[15]}}, load_half};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, load_half};
      default: load_data = mem_data;
    endcase
  end

  // Misalignment check: halves need even addresses, words (and lw-like encodings) need word alignment.
  always_comb begin
    misaligned = 1'b0;
    if (mem_valid && wb_sel == SEL_LOAD) begin
      case (funct3)
        F3_LB, F3_LBU: misaligned = 1'b0;
        F3_LH, F3_LHU: misaligned = off[0];
        default:       misaligned = (off != 2'b00);
      endcase
    end
  end

  // Writeback source select; the reserved encoding falls back to the ALU value.
  always_comb begin
    sel_data = ALU_result;
    case (wb_sel)
      SEL_LOAD: sel_data = load_data;
      SEL_LINK: sel_data = pc_plus4;
      default:  sel_data = ALU_result;
    endcase
  end

  // WB pipeline register: flush kills the valid/write bits, stall freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= '0;
    end else if (flush) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
    end else if (!stall) begin
      wb_valid     <= mem_valid;
      wb_reg_write <= mem_valid && reg_write_in && (rd_in != 5'd0) && !misaligned;
      wb_rd        <= rd_in;
      wb_data      <= sel_data;
    end
  end

  // Sticky misalign flag: only the first offending address is kept until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else if (advance && misaligned && !misalign_err) begin
      misalign_err  <= 1'b1;
      misalign_addr <= ALU_result;
    end
  end

  // Retired-instruction counter, wraps naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_count <= '0;
    end else if (advance && mem_valid) begin
      retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline boundary and writeback stage, directly downstream of the data-memory access stage.
- Takes the memory stage's combinational read word and the ALU result, and extracts and sign/zero-extends load data (lb/lh/lw/lbu/lhu).
- Selects the writeback source (ALU, load, link PC+4) and registers it into the WB stage.
- Drives the register-file write port and forwarding, flags misaligned loads, and counts retired instructions.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold WB register contents
- flush  in  1  insert bubble into WB
- mem_valid  in  1  MEM-stage instruction valid
- reg_write_in  in  1  instruction writes rd
- wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
- funct3  in  3  load size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- rd_in  in  5  destination register
- ALU_result  in  32  effective address / ALU value
- mem_data  in  32  word read from data memory, word-aligned via ALU_result[9:2]
- pc_plus4  in  32  link value
- wb_valid  out  1  WB holds valid instruction
- wb_reg_write  out  1  register-file write enable
- wb_rd  out  5  register-file write index
- wb_data  out  32  register-file write data / forwarding value
- misalign_err  out  1  sticky misaligned-load flag
- misalign_addr  out  32  address of first misaligned load
- retire_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, immediate): wb_valid, wb_reg_write, wb_rd, wb_data, misalign_err, misalign_addr and retire_count all go to 0.
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N.
- Load extraction is combinational in the MEM cycle, using byte offset off = ALU_result[1:0]:
  - lb/lbu: byte = mem_data[8*off+7 : 8*off], sign- or zero-extended.
  - lh/lhu: half = off[1] ? mem_data[31:16] : mem_data[15:0], sign- or zero-extended.
  - lw: mem_data unchanged.
  - Undefined funct3 with wb_sel=01: treated as lw.
- Misaligned load: wb_sel=01 and mem_valid and either (lh/lhu and off[0]=1) or (lw and off!=00).
  - The instruction still advances (wb_valid=1) but wb_reg_write=0.
  - If misalign_err is 0, set it and capture ALU_result into misalign_addr.
  - Both hold until rst; later misaligned loads do not overwrite the address.
- Register update priority per edge: flush > stall > normal.
  - flush: wb_valid=0 and wb_reg_write=0; wb_rd/wb_data don't-care (hold).
  - stall (no flush): all WB registers hold; no retire-count increment; no new misalign capture.
  - normal: wb_valid<=mem_valid; wb_reg_write<=mem_valid & reg_write_in & (rd_in!=0) & !misaligned; wb_rd<=rd_in; wb_data<=selected source.
- x0 protection: rd_in==0 never asserts wb_reg_write; wb_data is still registered.
- retire_count increments by 1 on each normal edge with mem_valid=1, including misaligned loads. It wraps modulo 2^CNT_W.
- Forwarding: wb_data/wb_rd/wb_reg_write are valid for EX forwarding the cycle after capture. A stalled WB keeps presenting the same values.
- Reset asserted mid-stall or mid-flush: reset wins immediately. The first edge after deassertion obeys the normal rules.

Test Plan:
- Reset: drive all inputs nonzero, pulse rst between edges -> all outputs 0 without any clock edge.
- Load extraction: mem_data=0x8899AABB, wb_sel=01, rd=5:
  - lb, ALU_result=0x11 -> wb_data=0xFFFFFFAA.
  - lbu, ALU_result=0x13 -> 0x00000088.
  - lh, ALU_result=0x12 -> 0xFFFF8899.
  - lhu, ALU_result=0x10 -> 0x0000AABB.
  - lw -> 0x8899AABB.
  - Each case: wb_reg_write=1 and wb_rd=5 one cycle later.
- Source select and x0: wb_sel=10, pc_plus4=0x104, rd=1 -> wb_data=0x104, write=1. Same with rd=0 -> write=0, wb_valid=1, retire_count+1.
- Misalign: lw at ALU_result=0x22 -> wb_reg_write=0, misalign_err=1, misalign_addr=0x22. A second misaligned lh at 0x31 leaves misalign_addr=0x22.
- Stall/flush: capture ALU value 0xDEAD, then stall 3 cycles with changing inputs -> outputs hold 0xDEAD and retire_count unchanged. Assert stall+flush together -> wb_valid=0, wb_reg_write=0.
- Counter wrap: CNT_W=4, 17 valid non-stalled instructions -> retire_count=1.
